// File: rtl/led_mode_mux.sv
// LED pattern selector: picks one of NUM_MODES LED patterns by mode_select and
// drives the pins with the configured polarity. A mode change blanks the LEDs
// for BLANK_CYCLES clocks before the new pattern is shown.
module led_mode_mux #(
  parameter int LED_W        = 8,
  parameter int NUM_MODES    = 4,
  parameter int SEL_W        = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           mode_select,
  input  logic [NUM_MODES*LED_W-1:0] mode_signals,
  output logic [LED_W-1:0]           led_n,
  output logic                       busy,
  output logic                       mode_changed,
  output logic [SEL_W-1:0]           active_mode
);

  localparam int CNT_W = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [LED_W-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t             r_state,   w_state_nxt;
  logic [SEL_W-1:0]   r_target,  w_target_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [SEL_W-1:0]   r_active,  w_active_nxt;
  logic [LED_W-1:0]   r_led,     w_led_nxt;
  logic               r_changed, w_changed_nxt;
  logic [LED_W-1:0]   w_pattern;

  // Pattern for a mode; modes outside 0..NUM_MODES-1 have an all-zero pattern.
  function automatic logic [LED_W-1:0] pattern_of(
    input logic [SEL_W-1:0]           sel,
    input logic [NUM_MODES*LED_W-1:0] sigs
  );
    logic [LED_W-1:0] p;
    p = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (sel == SEL_W'(m)) p = sigs[m*LED_W +: LED_W];
    end
    return p;
  endfunction

  // Converts an active-high pattern into the pin drive level.
  function automatic logic [LED_W-1:0] drive_on(input logic [LED_W-1:0] p);
    return (ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  assign w_pattern = pattern_of(r_active, mode_signals);

  // State and output registers; reset discards any pending switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_target  <= '0;
      r_cnt     <= '0;
      r_active  <= '0;
      r_led     <= LED_OFF;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_led     <= w_led_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  // Next-state logic: detect mode changes, run the blanking count, commit the mode.
  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_cnt_nxt     = r_cnt;
    w_active_nxt  = r_active;
    w_led_nxt     = LED_OFF;
    w_changed_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mode_select == r_active) begin
          w_led_nxt = drive_on(w_pattern);
        end else if (BLANK_CYCLES > 0) begin
          w_target_nxt = mode_select;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_BLANK;
        end else begin
          // No blanking: commit immediately, one OFF cycle while the pulse fires.
          w_active_nxt  = mode_select;
          w_changed_nxt = 1'b1;
        end
      end
      ST_BLANK: begin
        if (mode_select != r_target) begin
          // Request moved during blanking: restart the full blank toward it.
          w_target_nxt = mode_select;
          w_cnt_nxt    = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_active_nxt  = r_target;
          w_state_nxt   = ST_RUN;
          w_changed_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign led_n        = r_led;
  assign busy         = (r_state == ST_BLANK);
  assign mode_changed = r_changed;
  assign active_mode  = r_active;

endmodule

// File: tb/tb_led_mode_mux.sv
// Directed bench for led_mode_mux: one instance with blanking and active-low
// pins, one with immediate switching and active-high pins.
module tb_led_mode_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] pats;

  logic [7:0]  led_a, led_b;
  logic        busy_a, busy_b, mc_a, mc_b;
  logic [3:0]  act_a, act_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  led_mode_mux #(
    .LED_W(8), .NUM_MODES(4), .SEL_W(4), .BLANK_CYCLES(4), .ACTIVE_LOW(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode_select(sel_a), .mode_signals(pats),
    .led_n(led_a), .busy(busy_a), .mode_changed(mc_a), .active_mode(act_a)
  );

  led_mode_mux #(
    .LED_W(8), .NUM_MODES(4), .SEL_W(4), .BLANK_CYCLES(0), .ACTIVE_LOW(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode_select(sel_b), .mode_signals(pats),
    .led_n(led_b), .busy(busy_b), .mode_changed(mc_b), .active_mode(act_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mcnt;
    int pos;
    int busy_seen;
    int led_bad;

    rst_n = 1'b0;
    sel_a = 4'd0;
    sel_b = 4'd0;
    pats  = {8'hFF, 8'hA5, 8'h0F, 8'h01};

    // T1: reset values, then first pattern one cycle after release
    step(); step();
    chk("t1_led",    led_a,  8'hFF);
    chk("t1_busy",   busy_a, 1'b0);
    chk("t1_mc",     mc_a,   1'b0);
    chk("t1_act",    act_a,  4'd0);
    chk("t1_led_b",  led_b,  8'h00);
    rst_n = 1'b1;
    step();
    chk("t1_led_run",   led_a, 8'hFE);
    chk("t1_led_run_b", led_b, 8'h01);

    // T2: 0 -> 2 with a 4-cycle blank
    sel_a = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("t2_busy_%0d", i), busy_a, (i <= 4) ? 1'b1 : 1'b0);
      chk($sformatf("t2_mc_%0d", i),   mc_a,   (i == 5) ? 1'b1 : 1'b0);
      chk($sformatf("t2_led_%0d", i),  led_a,  (i <= 5) ? 8'hFF : 8'h5A);
    end
    chk("t2_act", act_a, 4'd2);

    // T3: go to mode 1, then 3, retarget to 2 two cycles into the blank
    sel_a = 4'd1;
    repeat (6) step();
    chk("t3_led_m1", led_a, 8'hF0);
    chk("t3_act_m1", act_a, 4'd1);
    sel_a = 4'd3;
    step(); step();
    sel_a = 4'd2;
    mcnt = 0;
    pos  = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (mc_a) begin
        mcnt++;
        pos = i;
      end
      if (i == 3) chk("t3_busy_restart", busy_a, 1'b1);
    end
    chk("t3_mc_count", mcnt, 1);
    chk("t3_mc_pos",   pos,  5);
    chk("t3_led",      led_a, 8'h5A);
    chk("t3_act",      act_a, 4'd2);

    // T4: invalid mode 9 shows OFF, then mode 1
    sel_a   = 4'd9;
    mcnt    = 0;
    pos     = 0;
    led_bad = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (mc_a) begin
        mcnt++;
        pos = i;
      end
      if (led_a !== 8'hFF) led_bad++;
    end
    chk("t4_mc_count", mcnt,    1);
    chk("t4_mc_pos",   pos,     5);
    chk("t4_led_off",  led_bad, 0);
    chk("t4_act",      act_a,   4'd9);
    sel_a = 4'd1;
    repeat (6) step();
    chk("t4_led_m1", led_a, 8'hF0);
    chk("t4_act_m1", act_a, 4'd1);

    // T5: async reset mid-blank toward mode 3
    sel_a = 4'd3;
    step(); step();
    chk("t5_busy_pre", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_led",  led_a,  8'hFF);
    chk("t5_busy", busy_a, 1'b0);
    chk("t5_mc",   mc_a,   1'b0);
    chk("t5_act",  act_a,  4'd0);
    sel_a = 4'd0;
    step();
    rst_n = 1'b1;
    mcnt      = 0;
    busy_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (mc_a) mcnt++;
      if (busy_a) busy_seen++;
      if (i == 1) chk("t5_led_first", led_a, 8'hFE);
    end
    chk("t5_mc_none",   mcnt,      0);
    chk("t5_busy_none", busy_seen, 0);
    chk("t5_act_after", act_a,     4'd0);

    // Pattern edit in a stable mode shows up one cycle later
    pats[7:0] = 8'h3C;
    step();
    chk("edit_led",   led_a, 8'hC3);
    chk("edit_led_b", led_b, 8'h3C);
    pats[7:0] = 8'h01;
    step();
    chk("edit_restore", led_a, 8'hFE);

    // T6: no blanking, active-high pins
    chk("t6_led_pre", led_b, 8'h01);
    sel_b = 4'd1;
    step();
    chk("t6_mc",    mc_b,   1'b1);
    chk("t6_led",   led_b,  8'h00);
    chk("t6_act",   act_b,  4'd1);
    chk("t6_busy1", busy_b, 1'b0);
    step();
    chk("t6_led_new", led_b,  8'h0F);
    chk("t6_mc_off",  mc_b,   1'b0);
    chk("t6_busy2",   busy_b, 1'b0);
    step();
    chk("t6_mc_quiet", mc_b,  1'b0);
    chk("t6_led_hold", led_b, 8'h0F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
